// File: rtl/syn_gpu_pkg.sv
// Shared constants for the GPU multiply-accelerator arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package syn_gpu_pkg;

  // Arbitration mode encodings
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Default parameter values
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MAX_OUTSTD = 4;
  localparam int DEF_ARB_MODE   = ARB_RR;

  // Fold an index in [0, 2n) back into [0, n).
  function automatic int wrap_idx(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/syn_gpu_tag_fifo.sv
// Generic synchronous FIFO used to remember which channel owns each in-flight job.
// Latency: push visible at pop_dat one cycle after push; pop_dat is the head combinationally.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; pop on empty is ignored.
//
// Ports:
//   core_clk, arst_n        clock, async active-low reset
//   push, push_dat          write strobe and data
//   pop, pop_dat            read strobe and current head
//   full, empty, occ        status and occupancy (0..DEPTH)
module syn_gpu_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                     core_clk,
  input  logic                     arst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (occ == (PTR_W+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge core_clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/syn_gpu_mulbry_arb.sv
// Arbitrates NUM_CH channels onto one in-order accelerator and routes results back by tag.
// Latency: grant same cycle as capture, acc_req_o next cycle; result to channel 1 cycle after acc_rsp_valid_i.
// Backpressure: issue register holds until acc_ready_i; no capture once MAX_OUTSTD jobs are held or in flight.
//
// Ports:
//   clk_ir, rst_sync_l                         clock, async active-low reset
//   ch_req_i, ch_opa_i, ch_opb_i               per-channel request and flattened operands (ch0 in LSBs)
//   ch_gnt_o                                   one-hot capture strobe (combinational)
//   ch_rsp_valid_o, ch_rsp_data_o              one-hot result strobe and shared result bus
//   acc_req_o, acc_opa_o, acc_opb_o, acc_ready_i   issue handshake to accelerator
//   acc_rsp_valid_i, acc_rsp_data_i            in-order accelerator results
//   outstd_cnt_o, err_orphan_o                 jobs held or in flight; sticky orphan-result flag
module syn_gpu_mulbry_arb
  import syn_gpu_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_OUTSTD = DEF_MAX_OUTSTD,
  parameter int ARB_MODE   = DEF_ARB_MODE
) (
  input  logic                          clk_ir,
  input  logic                          rst_sync_l,
  input  logic [NUM_CH-1:0]             ch_req_i,
  input  logic [NUM_CH*DATA_W-1:0]      ch_opa_i,
  input  logic [NUM_CH*DATA_W-1:0]      ch_opb_i,
  output logic [NUM_CH-1:0]             ch_gnt_o,
  output logic [NUM_CH-1:0]             ch_rsp_valid_o,
  output logic [DATA_W-1:0]             ch_rsp_data_o,
  output logic                          acc_req_o,
  output logic [DATA_W-1:0]             acc_opa_o,
  output logic [DATA_W-1:0]             acc_opb_o,
  input  logic                          acc_ready_i,
  input  logic                          acc_rsp_valid_i,
  input  logic [DATA_W-1:0]             acc_rsp_data_i,
  output logic [$clog2(MAX_OUTSTD):0]   outstd_cnt_o,
  output logic                          err_orphan_o
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(MAX_OUTSTD) + 1;

  // Issue register
  logic              iss_vld;
  logic [DATA_W-1:0] iss_opa;
  logic [DATA_W-1:0] iss_opb;
  logic [IDX_W-1:0]  iss_tag;

  logic [IDX_W-1:0]  rr_ptr;

  logic              win_vld;
  logic [IDX_W-1:0]  win_idx;
  logic [DATA_W-1:0] win_opa;
  logic [DATA_W-1:0] win_opb;

  logic              iss_free;
  logic              acc_acpt;
  logic              cap;
  logic              rsp_pop;

  logic              fifo_full;
  logic              fifo_empty;
  logic [IDX_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  fifo_occ;

  assign acc_req_o = iss_vld;
  assign acc_opa_o = iss_opa;
  assign acc_opb_o = iss_opb;

  assign acc_acpt = iss_vld && acc_ready_i;
  assign iss_free = !iss_vld || acc_ready_i;

  assign outstd_cnt_o = fifo_occ + CNT_W'(iss_vld);

  // Count check uses the current-cycle value only: a response popping this
  // cycle does not free a slot until next cycle. The fifo_full term is
  // implied by the count check but keeps the FIFO safe on its own.
  // Gating with the reset keeps the combinational grant low while in reset.
  assign cap = rst_sync_l && iss_free && win_vld && !fifo_full
            && (outstd_cnt_o < CNT_W'(MAX_OUTSTD));

  assign ch_gnt_o = cap ? (NUM_CH'(1) << win_idx) : '0;

  // Winner search: round-robin starts one past the last winner, fixed
  // priority always starts at channel 0.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ARB_MODE == ARB_FIXED) cand = i;
      else                       cand = wrap_idx(int'(rr_ptr) + 1 + i, NUM_CH);
      cand_idx = IDX_W'(cand);
      if (!win_vld && ch_req_i[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  assign win_opa = ch_opa_i[win_idx*DATA_W +: DATA_W];
  assign win_opb = ch_opb_i[win_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      iss_vld <= 1'b0;
      iss_opa <= '0;
      iss_opb <= '0;
      iss_tag <= '0;
      rr_ptr  <= IDX_W'(NUM_CH - 1);
    end else begin
      if (cap) begin
        iss_vld <= 1'b1;
        iss_opa <= win_opa;
        iss_opb <= win_opb;
        iss_tag <= win_idx;
        rr_ptr  <= win_idx;
      end else if (acc_acpt) begin
        iss_vld <= 1'b0;
      end
    end
  end

  // Accelerator answers in order, so the FIFO head owns each result.
  assign rsp_pop = acc_rsp_valid_i && !fifo_empty;

  syn_gpu_tag_fifo #(
    .W     (IDX_W),
    .DEPTH (MAX_OUTSTD)
  ) u_tag_fifo (
    .core_clk (clk_ir),
    .arst_n   (rst_sync_l),
    .push     (acc_acpt),
    .push_dat (iss_tag),
    .pop      (rsp_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .occ      (fifo_occ)
  );

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      ch_rsp_valid_o <= '0;
      ch_rsp_data_o  <= '0;
      err_orphan_o   <= 1'b0;
    end else begin
      ch_rsp_valid_o <= rsp_pop ? (NUM_CH'(1) << fifo_head) : '0;
      if (rsp_pop) ch_rsp_data_o <= acc_rsp_data_i;
      if (acc_rsp_valid_i && fifo_empty) err_orphan_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_syn_gpu_mulbry_arb.sv
// Self-checking bench: round-robin and fixed-priority instances share stimulus;
// a scoreboard of expected (channel, result) pairs is filled at grant time.
// A small accelerator model multiplies accepted operands and answers in order.
module tb_syn_gpu_mulbry_arb;
  import syn_gpu_pkg::*;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int CW = $clog2(MO) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NC-1:0]    ch_req;
  logic [NC*DW-1:0] ch_opa, ch_opb;
  logic             acc_ready, acc_rsp_vld;
  logic [DW-1:0]    acc_rsp_dat;

  logic [NC-1:0] gnt_a, rspv_a, gnt_b, rspv_b;
  logic [DW-1:0] rspd_a, rspd_b, aopa_a, aopb_a, aopa_b, aopb_b;
  logic          areq_a, areq_b, orph_a, orph_b;
  logic [CW-1:0] cnt_a, cnt_b;

  syn_gpu_mulbry_arb #(.NUM_CH(NC), .DATA_W(DW), .MAX_OUTSTD(MO), .ARB_MODE(ARB_RR)) u_rr (
    .clk_ir(clk), .rst_sync_l(rst_n), .ch_req_i(ch_req), .ch_opa_i(ch_opa), .ch_opb_i(ch_opb),
    .ch_gnt_o(gnt_a), .ch_rsp_valid_o(rspv_a), .ch_rsp_data_o(rspd_a),
    .acc_req_o(areq_a), .acc_opa_o(aopa_a), .acc_opb_o(aopb_a), .acc_ready_i(acc_ready),
    .acc_rsp_valid_i(acc_rsp_vld), .acc_rsp_data_i(acc_rsp_dat),
    .outstd_cnt_o(cnt_a), .err_orphan_o(orph_a));

  syn_gpu_mulbry_arb #(.NUM_CH(NC), .DATA_W(DW), .MAX_OUTSTD(MO), .ARB_MODE(ARB_FIXED)) u_fx (
    .clk_ir(clk), .rst_sync_l(rst_n), .ch_req_i(ch_req), .ch_opa_i(ch_opa), .ch_opb_i(ch_opb),
    .ch_gnt_o(gnt_b), .ch_rsp_valid_o(rspv_b), .ch_rsp_data_o(rspd_b),
    .acc_req_o(areq_b), .acc_opa_o(aopa_b), .acc_opb_o(aopb_b), .acc_ready_i(acc_ready),
    .acc_rsp_valid_i(acc_rsp_vld), .acc_rsp_data_i(acc_rsp_dat),
    .outstd_cnt_o(cnt_b), .err_orphan_o(orph_b));

  // Observed instance: 0 = round-robin, 1 = fixed priority
  logic          sel;
  logic [NC-1:0] obs_gnt, obs_rspv;
  logic [DW-1:0] obs_rspd, obs_aopa, obs_aopb;
  logic          obs_areq, obs_orph;
  logic [CW-1:0] obs_cnt;
  assign obs_gnt  = sel ? gnt_b  : gnt_a;
  assign obs_rspv = sel ? rspv_b : rspv_a;
  assign obs_rspd = sel ? rspd_b : rspd_a;
  assign obs_aopa = sel ? aopa_b : aopa_a;
  assign obs_aopb = sel ? aopb_b : aopb_a;
  assign obs_areq = sel ? areq_b : areq_a;
  assign obs_orph = sel ? orph_b : orph_a;
  assign obs_cnt  = sel ? cnt_b  : cnt_a;

  typedef struct { int ch; logic [DW-1:0] dat; } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] acc_q[$];
  int            gnt_log[$];
  logic [DW-1:0] opa_v [NC];
  logic [DW-1:0] opb_v [NC];
  logic [NC-1:0] req_nxt, drop_on_gnt;
  logic          ready_nxt;
  int            rsp_credit;
  bit            orphan_pulse;
  int            errors = 0;
  int            checks = 0;

  // One clock cycle: drive at negedge, observe 1ns later.
  task automatic step();
    exp_t          e;
    int            k;
    logic [DW-1:0] prod;
    @(negedge clk);
    ch_req    = req_nxt;
    acc_ready = ready_nxt;
    for (int i = 0; i < NC; i++) begin
      ch_opa[i*DW +: DW] = opa_v[i];
      ch_opb[i*DW +: DW] = opb_v[i];
    end
    if (orphan_pulse) begin
      acc_rsp_vld  = 1'b1;
      acc_rsp_dat  = 32'hDEAD_BEEF;
      orphan_pulse = 1'b0;
    end else if (rsp_credit > 0 && acc_q.size() > 0) begin
      acc_rsp_vld = 1'b1;
      acc_rsp_dat = acc_q.pop_front();
      rsp_credit--;
    end else begin
      acc_rsp_vld = 1'b0;
    end
    #1;
    if (obs_rspv !== '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: ch_rsp_valid_o=%b with nothing outstanding", obs_rspv);
      end else begin
        e = sb.pop_front();
        if (obs_rspv !== (NC'(1) << e.ch) || obs_rspd !== e.dat) begin
          errors++;
          $display("FAIL rsp_route: got valid=%b data=%h, want valid=%b data=%h",
                   obs_rspv, obs_rspd, NC'(1) << e.ch, e.dat);
        end
      end
    end
    if (obs_gnt !== '0) begin
      checks++;
      if ($countones(obs_gnt) != 1) begin
        errors++;
        $display("FAIL gnt_onehot: ch_gnt_o=%b, want exactly one bit", obs_gnt);
      end else begin
        k = 0;
        for (int b = 0; b < NC; b++) if (obs_gnt[b]) k = b;
        gnt_log.push_back(k);
        prod = opa_v[k] * opb_v[k];
        e.ch = k;
        e.dat = prod;
        sb.push_back(e);
        opa_v[k] = $urandom;
        opb_v[k] = $urandom;
        if (drop_on_gnt[k]) req_nxt[k] = 1'b0;
      end
    end
    if (obs_areq && acc_ready) begin
      prod = obs_aopa * obs_aopb;
      acc_q.push_back(prod);
    end
  endtask

  task automatic drain();
    rsp_credit = 1000;
    req_nxt    = '0;
    ready_nxt  = 1'b1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) step();
  endtask

  task automatic apply_reset(input bit s);
    sel = s;
    req_nxt = '0; drop_on_gnt = '0; ready_nxt = 1'b1; rsp_credit = 0; orphan_pulse = 1'b0;
    ch_req = '0; ch_opa = '0; ch_opb = '0; acc_ready = 1'b1; acc_rsp_vld = 1'b0; acc_rsp_dat = '0;
    rst_n = 1'b0;
    sb.delete(); acc_q.delete(); gnt_log.delete();
    for (int i = 0; i < NC; i++) begin
      opa_v[i] = $urandom;
      opb_v[i] = $urandom;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ch_req = '1; acc_ready = 1'b1; acc_rsp_vld = 1'b0;
    #1;
    checks++;
    if (gnt_a !== '0 || gnt_b !== '0) begin
      errors++; $display("FAIL reset_gnt: got %b/%b, want 0", gnt_a, gnt_b);
    end
    checks++;
    if (rspv_a !== '0 || rspd_a !== '0 || rspv_b !== '0 || rspd_b !== '0) begin
      errors++; $display("FAIL reset_rsp: got %b %h, want 0", rspv_a, rspd_a);
    end
    checks++;
    if (areq_a !== 1'b0 || aopa_a !== '0 || aopb_a !== '0 || areq_b !== 1'b0) begin
      errors++; $display("FAIL reset_acc: got req=%b opa=%h opb=%h, want 0", areq_a, aopa_a, aopb_a);
    end
    checks++;
    if (cnt_a !== '0 || orph_a !== 1'b0 || cnt_b !== '0 || orph_b !== 1'b0) begin
      errors++; $display("FAIL reset_cnt: got cnt=%0d orph=%b, want 0", cnt_a, orph_a);
    end
  endtask

  task automatic test_round_robin();
    apply_reset(0);
    req_nxt = '1; rsp_credit = 1000;
    for (int c = 0; c < 20 && gnt_log.size() < 5; c++) step();
    req_nxt = '0;
    checks++;
    if (gnt_log.size() < 5) begin
      errors++; $display("FAIL rr_timeout: got %0d grants, want 5", gnt_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (gnt_log[i] != i % NC) begin
          errors++; $display("FAIL rr_order[%0d]: got ch %0d, want ch %0d", i, gnt_log[i], i % NC);
        end
      end
    end
    drain();
    checks++;
    if (sb.size() != 0 || obs_cnt !== '0) begin
      errors++; $display("FAIL rr_drain: got %0d pending cnt=%0d, want 0", sb.size(), obs_cnt);
    end
  endtask

  task automatic test_fixed_priority();
    apply_reset(1);
    req_nxt = 4'b1010; rsp_credit = 1000;
    for (int c = 0; c < 20 && gnt_log.size() < 4; c++) step();
    req_nxt = 4'b1000;
    for (int c = 0; c < 20 && gnt_log.size() < 6; c++) step();
    req_nxt = '0;
    checks++;
    if (gnt_log.size() < 6) begin
      errors++; $display("FAIL fx_timeout: got %0d grants, want 6", gnt_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (gnt_log[i] != ((i < 4) ? 1 : 3)) begin
          errors++; $display("FAIL fx_order[%0d]: got ch %0d, want ch %0d", i, gnt_log[i], (i < 4) ? 1 : 3);
        end
      end
    end
    drain();
    checks++;
    if (sb.size() != 0 || obs_cnt !== '0) begin
      errors++; $display("FAIL fx_drain: got %0d pending cnt=%0d, want 0", sb.size(), obs_cnt);
    end
  endtask

  task automatic test_outstanding_limit();
    apply_reset(0);
    req_nxt = '1; rsp_credit = 0;
    repeat (8) step();
    checks++;
    if (gnt_log.size() != MO || obs_cnt !== CW'(MO)) begin
      errors++; $display("FAIL limit_full: got %0d grants cnt=%0d, want %0d and %0d",
                         gnt_log.size(), obs_cnt, MO, MO);
    end
    rsp_credit = 1;
    repeat (6) step();
    checks++;
    if (gnt_log.size() != MO + 1 || obs_cnt !== CW'(MO)) begin
      errors++; $display("FAIL limit_refill: got %0d grants cnt=%0d, want %0d and %0d",
                         gnt_log.size(), obs_cnt, MO + 1, MO);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [DW-1:0] ea, eb;
    apply_reset(0);
    ready_nxt = 1'b0; req_nxt = 4'b0101; drop_on_gnt = 4'b0101; rsp_credit = 1000;
    ea = opa_v[0]; eb = opb_v[0];
    step();
    checks++;
    if (gnt_log.size() != 1 || gnt_log[0] != 0) begin
      errors++; $display("FAIL stall_first: got %0d grants, want one grant to ch 0", gnt_log.size());
    end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (obs_areq !== 1'b1 || obs_aopa !== ea || obs_aopb !== eb || obs_cnt !== CW'(1)
          || gnt_log.size() != 1) begin
        errors++; $display("FAIL stall_hold[%0d]: got req=%b opa=%h opb=%h cnt=%0d grants=%0d, want 1 %h %h 1 1",
                           c, obs_areq, obs_aopa, obs_aopb, obs_cnt, gnt_log.size(), ea, eb);
      end
    end
    ready_nxt = 1'b1;
    step();
    checks++;
    if (gnt_log.size() != 2 || gnt_log[gnt_log.size()-1] != 2) begin
      errors++; $display("FAIL stall_release: got %0d grants, want second grant to ch 2", gnt_log.size());
    end
    drain();
  endtask

  task automatic test_orphan();
    apply_reset(0);
    req_nxt = 4'b0011; drop_on_gnt = '1; rsp_credit = 0;
    repeat (4) step();
    checks++;
    if (obs_cnt !== CW'(2)) begin
      errors++; $display("FAIL orphan_setup: got cnt=%0d, want 2", obs_cnt);
    end
    apply_reset(0);
    orphan_pulse = 1'b1;
    step();
    step();
    checks++;
    if (obs_orph !== 1'b1 || obs_rspv !== '0 || obs_rspd !== '0) begin
      errors++; $display("FAIL orphan_flag: got err=%b valid=%b data=%h, want 1 0 0", obs_orph, obs_rspv, obs_rspd);
    end
    repeat (3) step();
    checks++;
    if (obs_orph !== 1'b1) begin
      errors++; $display("FAIL orphan_sticky: got err=%b, want 1", obs_orph);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset(0);
    req_nxt = 4'b0011; drop_on_gnt = '1; rsp_credit = 0;
    for (int c = 0; c < 10 && !(gnt_log.size() == 2 && obs_cnt === CW'(2) && !obs_areq); c++) step();
    req_nxt = 4'b0100; rsp_credit = 1;
    step();
    checks++;
    if (gnt_log.size() != 3 || gnt_log[gnt_log.size()-1] != 2) begin
      errors++; $display("FAIL b2b_capture: got %0d grants, want third grant to ch 2", gnt_log.size());
    end
    step();
    checks++;
    if (obs_cnt !== CW'(2) || obs_rspv !== 4'b0001) begin
      errors++; $display("FAIL b2b_count: got cnt=%0d valid=%b, want 2 0001", obs_cnt, obs_rspv);
    end
    drain();
    checks++;
    if (sb.size() != 0 || obs_cnt !== '0) begin
      errors++; $display("FAIL b2b_drain: got %0d pending cnt=%0d, want 0", sb.size(), obs_cnt);
    end
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_outstanding_limit();
    test_stall();
    test_orphan();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
